// File: rtl/data_memory_lsu_segmented.sv
// MEM-stage load/store unit with embedded word RAM, byte/half lane handling and optional wait states.
// Optional perf counters enabled by defining DMEM_PERF_COUNTERS_EN.
module data_memory_lsu_segmented #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] output_data,
    output logic        stall,
    output logic        access_fault
`ifdef DMEM_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [31:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic active, fault, req, complete, stall_int, wr_en;
    logic [3:0]  be;
    logic [31:0] wdata, rword, ld_val;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign idx = address[ADDR_WIDTH+1:2];

    always_comb begin
        active = mem_read | mem_write;
        fault  = active & ((mem_read & mem_write)
                 | (funct3 == 3'b011) | (funct3[2:1] == 2'b11)
                 | (mem_write & (funct3[2:1] == 2'b10))
                 | ((funct3[1:0] == 2'b01) & address[0])
                 | ((funct3[1:0] == 2'b10) & (address[1:0] != 2'b00)));
        req    = (mem_read ^ mem_write) & ~fault;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        complete  = 1'b0;
        stall_int = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (ZERO_WAIT) begin
                        complete = 1'b1;
                    end else begin
                        stall_int = 1'b1;
                        cnt_d     = WS_INIT;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                // A faulting request holds the FSM; a vanished one is a flush.
                if (!active) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (req) begin
                    if (cnt_q != 4'd0) begin
                        stall_int = 1'b1;
                        cnt_d     = cnt_q - 4'd1;
                    end else begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wdata = write_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << address[1:0];
                wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                be    = address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign wr_en = rst_n & complete & mem_write;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) begin
                mem_q[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rword = mem_q[idx];
        case (address[1:0])
            2'b00:   bsel = rword[7:0];
            2'b01:   bsel = rword[15:8];
            2'b10:   bsel = rword[23:16];
            default: bsel = rword[31:24];
        endcase
        hsel = address[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            3'b000:  ld_val = {{24{bsel[7]}}, bsel};
            3'b100:  ld_val = {24'd0, bsel};
            3'b001:  ld_val = {{16{hsel[15]}}, hsel};
            3'b101:  ld_val = {16'd0, hsel};
            3'b010:  ld_val = rword;
            default: ld_val = 32'd0;
        endcase
    end

    assign output_data  = (rst_n && complete && mem_read) ? ld_val : 32'd0;
    assign stall        = rst_n & stall_int;
    assign access_fault = rst_n & fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DMEM_PERF_COUNTERS_EN
    logic [31:0] loads_q, stores_q, stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loads_q  <= 32'd0;
            stores_q <= 32'd0;
            stalls_q <= 32'd0;
        end else begin
            if (complete && mem_read)  loads_q  <= loads_q + 32'd1;
            if (complete && mem_write) stores_q <= stores_q + 32'd1;
            if (stall)                 stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_loads        = loads_q;
    assign perf_stores       = stores_q;
    assign perf_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_data_memory_lsu_segmented.sv
// Directed bench: one zero-wait instance and one three-wait-state instance share request inputs.
module tb_data_memory_lsu_segmented;

    logic        clk = 1'b0;
    logic        rst0_n, rst3_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] address, write_data;
    logic [31:0] out0, out3;
    logic        stall0, stall3, fault0, fault3;
    int          n_pass = 0;
    int          n_total = 0;
`ifdef DMEM_PERF_COUNTERS_EN
    logic [31:0] pl0, ps0, pc0, pl3, ps3, pc3;
`endif

    always #5 clk = ~clk;

    data_memory_lsu_segmented #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .write_data(write_data),
        .output_data(out0), .stall(stall0), .access_fault(fault0)
`ifdef DMEM_PERF_COUNTERS_EN
        , .perf_loads(pl0), .perf_stores(ps0), .perf_stall_cycles(pc0)
`endif
    );

    data_memory_lsu_segmented #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .address(address), .write_data(write_data),
        .output_data(out3), .stall(stall3), .access_fault(fault3)
`ifdef DMEM_PERF_COUNTERS_EN
        , .perf_loads(pl3), .perf_stores(ps3), .perf_stall_cycles(pc3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%h exp=%h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply a request and wait until mid-cycle where combinational outputs are settled.
    task automatic step(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        mem_read   = r;
        mem_write  = w;
        funct3     = f3;
        address    = a;
        write_data = d;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Hold a request on the wait-state instance for four cycles: 3 stalls then completion.
    task automatic ws_access(input string tag, input logic r, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_ld);
        for (int i = 0; i < 4; i++) begin
            step(r, w, f3, a, d);
            chk({tag, "_stall"}, 32'(stall3), (i < 3) ? 32'd1 : 32'd0);
            chk({tag, "_out"}, out3, (i == 3) ? exp_ld : 32'd0);
            nxt();
        end
    endtask

    initial begin
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("rst_out0", out0, 32'h0);
        chk("rst_stall3", 32'(stall3), 32'h0);
        mem_write = 1'b1;
        #1;
        chk("rst_fault0", 32'(fault0), 32'h0);
        nxt();
        rst0_n = 1'b1;
        rst3_n = 1'b1;

        // Zero-wait store then load
        step(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_stall0", 32'(stall0), 32'h0);
        chk("sw_out0", out0, 32'h0);
        nxt();
        step(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_out0", out0, 32'hDEADBEEF);
        chk("lw_stall0", 32'(stall0), 32'h0);
        nxt();

        // Sign/zero extension of sub-word loads
        step(1'b0, 1'b1, 3'b010, 32'h20, 32'h8081F0F1); nxt();
        step(1'b1, 1'b0, 3'b000, 32'h20, 32'h0); chk("lb_20", out0, 32'hFFFFFFF1); nxt();
        step(1'b1, 1'b0, 3'b100, 32'h23, 32'h0); chk("lbu_23", out0, 32'h00000080); nxt();
        step(1'b1, 1'b0, 3'b001, 32'h22, 32'h0); chk("lh_22", out0, 32'hFFFF8081); nxt();
        step(1'b1, 1'b0, 3'b101, 32'h20, 32'h0); chk("lhu_20", out0, 32'h0000F0F1); nxt();
        step(1'b0, 1'b0, 3'b010, 32'h20, 32'h0); chk("idle_out0", out0, 32'h0); nxt();

        // Partial stores
        step(1'b0, 1'b1, 3'b010, 32'h20, 32'h0); nxt();
        step(1'b0, 1'b1, 3'b000, 32'h21, 32'h5555_55AA); nxt();
        step(1'b1, 1'b0, 3'b010, 32'h20, 32'h0); chk("sb_lw", out0, 32'h0000AA00); nxt();
        step(1'b0, 1'b1, 3'b001, 32'h22, 32'h7777_1234); nxt();
        step(1'b1, 1'b0, 3'b010, 32'h20, 32'h0); chk("sh_lw", out0, 32'h1234AA00); nxt();
        step(1'b1, 1'b0, 3'b010, 32'h1020, 32'h0); chk("alias_lw", out0, 32'h1234AA00); nxt();

        // Faults leave RAM untouched
        step(1'b0, 1'b1, 3'b010, 32'h00, 32'h11223344); nxt();
        step(1'b1, 1'b0, 3'b010, 32'h22, 32'h0);
        chk("f_lw22", 32'(fault0), 32'h1);
        chk("f_lw22_out", out0, 32'h0);
        nxt();
        step(1'b0, 1'b1, 3'b001, 32'h01, 32'hFFFF);
        chk("f_sh01", 32'(fault0), 32'h1);
        chk("f_sh01_stl3", 32'(stall3), 32'h0);
        nxt();
        step(1'b0, 1'b1, 3'b011, 32'h00, 32'h0); chk("f_f3_011", 32'(fault0), 32'h1); nxt();
        step(1'b0, 1'b1, 3'b100, 32'h00, 32'h0); chk("f_st_100", 32'(fault0), 32'h1); nxt();
        step(1'b1, 1'b1, 3'b010, 32'h00, 32'h0); chk("f_rw", 32'(fault0), 32'h1); nxt();
        step(1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
        chk("f_reread", out0, 32'h11223344);
        chk("f_none", 32'(fault0), 32'h0);
        nxt();

        // Wait-state instance: clean start
        step(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        rst3_n = 1'b0;
        nxt();
        rst3_n = 1'b1;
        ws_access("ws_sw", 1'b0, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0);
        ws_access("ws_lw", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D);

        // Flush while busy: store abandoned
        step(1'b0, 1'b1, 3'b010, 32'h30, 32'h55555555); chk("fl_st1", 32'(stall3), 32'h1); nxt();
        step(1'b0, 1'b1, 3'b010, 32'h30, 32'h55555555); chk("fl_st2", 32'(stall3), 32'h1); nxt();
        step(1'b0, 1'b0, 3'b010, 32'h30, 32'h0); chk("fl_drop", 32'(stall3), 32'h0); nxt();
        ws_access("fl_lw", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D);

        // Reset during the second stall cycle of a store
        step(1'b0, 1'b1, 3'b010, 32'h30, 32'h99999999); chk("rb_st1", 32'(stall3), 32'h1); nxt();
        step(1'b0, 1'b1, 3'b010, 32'h30, 32'h99999999); chk("rb_st2", 32'(stall3), 32'h1);
        #2;
        rst3_n = 1'b0;
        #1;
        chk("rb_stall0", 32'(stall3), 32'h0);
`ifdef DMEM_PERF_COUNTERS_EN
        chk("rb_perf_ld", pl3, 32'h0);
        chk("rb_perf_st", ps3, 32'h0);
        chk("rb_perf_stl", pc3, 32'h0);
`endif
        nxt();
        step(1'b0, 1'b0, 3'b010, 32'h30, 32'h0);
        nxt();
        rst3_n = 1'b1;
        ws_access("rb_lw", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu_segmented.md
Name: data_memory_lsu_segmented

Overview:
MEM-stage load/store unit with embedded data RAM for the segmented RISC-V core. It sits directly upstream of the MEM/WB pipeline register and consumes the EX/MEM register outputs (ALU result as address, store data, funct3, mem_read/mem_write). It produces the load value that MEM/WB captures as data_memory_out_in. It also drives a stall to the hazard unit while a configurable number of wait states elapse.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words
WAIT_STATES, 0, extra stall cycles per load/store; legal range 0..15

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
mem_read  in  1  load request, from EX/MEM
mem_write  in  1  store request, from EX/MEM
funct3  in  3  access size/sign, instruction[14:12]
address  in  32  byte address, from EX/MEM alu_result_out
write_data  in  32  store data, rs2 value from EX/MEM
output_data  out  32  aligned and extended load value, to MEM/WB data_memory_out_in
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB
access_fault  out  1  misaligned or illegal access in current cycle

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, wait counter=0. While rst_n=0, stall, access_fault and output_data are forced to 0. RAM contents are not reset.
- Word index = address[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias and wrap modulo RAM size.
- req = (mem_read XOR mem_write) and not fault.
- Fault conditions:
  - mem_read and mem_write both set.
  - funct3 in {011, 110, 111}.
  - funct3 in {100, 101} on a store.
  - Half access with address[0]=1.
  - Word access with address[1:0] != 00.
- Fault response (combinational): access_fault=1, no RAM write, output_data=0, stall=0, state unchanged.
- Stores:
  - SB (000): writes byte lane address[1:0] with write_data[7:0].
  - SH (001): writes lanes {address[1],1'b1}:{address[1],1'b0} with write_data[15:0].
  - SW (010): writes all lanes.
  - Write occurs on the rising clk edge of the completing cycle only.
- Loads: output_data from combinational RAM read, selected by address[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Valid only in the completing cycle; 0 in all other cycles and when mem_read=0.
- FSM:
  - IDLE:
    - If req and WAIT_STATES=0: complete in the same cycle, stall=0, remain IDLE.
    - If req and WAIT_STATES>0: stall=1, counter<=WAIT_STATES-1, go to BUSY.
  - BUSY:
    - counter!=0: stall=1, counter<=counter-1.
    - counter==0: completing cycle, stall=0, store written / load presented, go to IDLE.
  - Each access therefore costs exactly WAIT_STATES stall cycles.
  - The request stays stable throughout because upstream is frozen. A request seen in IDLE is always a new instruction.
- Back-to-back accesses: the cycle after a completing cycle is IDLE and may start the next access immediately, with no dead cycle.
- Request dropped in BUSY (mem_read=mem_write=0, i.e. a flush): return to IDLE, stall=0, no write.
- Reset mid-BUSY: immediate IDLE, pending store discarded.

Optional Feature:
Macro DMEM_PERF_COUNTERS_EN.
- Defined: adds outputs perf_loads, perf_stores and perf_stall_cycles, each 32 bits.
  - perf_loads and perf_stores increment on each completing load/store.
  - perf_stall_cycles increments every cycle stall=1.
  - All three reset to 0 on rst_n=0 and wrap modulo 2**32.
- Undefined: these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
1. WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> output_data=0xDEADBEEF in the LW cycle, stall never 1.
2. Word 0x8081F0F1 @0x20:
   - LB @0x20 -> 0xFFFFFFF1
   - LBU @0x23 -> 0x00000080
   - LH @0x22 -> 0xFFFF8081
   - LHU @0x20 -> 0x0000F0F1
3. SB 0xAA @0x21 onto word 0x00000000 -> LW @0x20 reads 0x0000AA00. SH 0x1234 @0x22 -> LW reads 0x1234AA00.
4. WAIT_STATES=3: LW -> stall=1 for exactly 3 cycles, then 1 completing cycle with valid data. Back-to-back SW+LW gives 3+1+3+1 cycles.
5. Faults -> access_fault=1, stall=0, RAM unchanged on reread:
   - LW @0x22
   - SH @0x01
   - funct3=011
   - mem_read=mem_write=1
6. WAIT_STATES=3: assert rst_n=0 during the second stall cycle of a SW -> stall=0 immediately, the targeted word still holds its old value. With DMEM_PERF_COUNTERS_EN, all counters read 0.
